// File: rtl/vga_pkg.sv
// Shared VGA screen geometry, field widths and arbiter state encodings
// for the pixel-port arbiter and its round-robin picker.
package vga_pkg;
  localparam int X_SCREEN_PIXELS = 160;
  localparam int Y_SCREEN_PIXELS = 120;
  localparam int X_W             = 8;
  localparam int Y_W             = 7;
  localparam int COLOUR_W        = 3;
  localparam int OWNER_W         = 3;
  localparam int MAX_CLIENTS     = 8;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: selects the first requester strictly
// after the pointer, wrapping, and reports it as one-hot plus index.
module rr_picker
  import vga_pkg::*;
#(
  parameter int N_CLIENTS = 4
) (
  input  logic [N_CLIENTS-1:0] req,
  input  logic [OWNER_W-1:0]   ptr,
  output logic [N_CLIENTS-1:0] gnt,
  output logic [OWNER_W-1:0]   idx,
  output logic                 any
);

  logic [MAX_CLIENTS-1:0] req_w;
  logic [OWNER_W-1:0]     cand;

  always_comb begin
    req_w = MAX_CLIENTS'(req);
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    gnt   = '0;
    for (int i = 1; i <= N_CLIENTS; i++) begin
      cand = OWNER_W'((int'(ptr) + i) % N_CLIENTS);
      if (!any && req_w[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    for (int j = 0; j < N_CLIENTS; j++) begin
      gnt[j] = any && (int'(idx) == j);
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the VGA pixel-write port among drawing engines;
// registers and clips the owner's pixel stream and enforces a hold limit.
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int N_CLIENTS       = 4,
  parameter int X_SCREEN_PIXELS = vga_pkg::X_SCREEN_PIXELS,
  parameter int Y_SCREEN_PIXELS = vga_pkg::Y_SCREEN_PIXELS,
  parameter int MAX_HOLD        = 19210
) (
  input  logic                            iClock,
  input  logic                            iResetn,
  input  logic [N_CLIENTS-1:0]            iReq,
  input  logic [N_CLIENTS-1:0]            iValid,
  input  logic [N_CLIENTS-1:0]            iLast,
  input  logic [X_W*N_CLIENTS-1:0]        iX,
  input  logic [Y_W*N_CLIENTS-1:0]        iY,
  input  logic [COLOUR_W*N_CLIENTS-1:0]   iColour,
  output logic [N_CLIENTS-1:0]            oGnt,
  output logic [X_W-1:0]                  oX,
  output logic [Y_W-1:0]                  oY,
  output logic [COLOUR_W-1:0]             oColour,
  output logic                            oPlot,
  output logic                            oBusy,
  output logic [OWNER_W-1:0]              oOwner,
  output logic                            oTimeout,
  output logic                            oClipped
);

  localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (int'(x) < X_SCREEN_PIXELS) && (int'(y) < Y_SCREEN_PIXELS);
  endfunction

  arb_state_t           state, state_nxt;
  logic [OWNER_W-1:0]   owner, owner_nxt, ptr, ptr_nxt;
  logic [N_CLIENTS-1:0] gnt_nxt;
  logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
  logic                 timeout_nxt;

  logic [N_CLIENTS-1:0] pick_gnt;
  logic [OWNER_W-1:0]   pick_idx;
  logic                 pick_any;

  // Widen per-client fields to 8 entries so a 3-bit owner index is always in range.
  logic [MAX_CLIENTS-1:0] req_w, vld_w, last_w;
  logic [X_W-1:0]         x_arr [MAX_CLIENTS];
  logic [Y_W-1:0]         y_arr [MAX_CLIENTS];
  logic [COLOUR_W-1:0]    c_arr [MAX_CLIENTS];

  logic                 vld_p0, last_p0, drop_p0, hold_exp_p0, rel_p0, on_scr_p0;
  logic [X_W-1:0]       x_p0;
  logic [Y_W-1:0]       y_p0;
  logic [COLOUR_W-1:0]  c_p0;

  rr_picker #(.N_CLIENTS(N_CLIENTS)) u_picker (
    .req (iReq),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    req_w  = MAX_CLIENTS'(iReq);
    vld_w  = MAX_CLIENTS'(iValid);
    last_w = MAX_CLIENTS'(iLast);
    for (int k = 0; k < MAX_CLIENTS; k++) begin
      x_arr[k] = '0;
      y_arr[k] = '0;
      c_arr[k] = '0;
    end
    for (int k = 0; k < N_CLIENTS; k++) begin
      x_arr[k] = iX[X_W*k +: X_W];
      y_arr[k] = iY[Y_W*k +: Y_W];
      c_arr[k] = iColour[COLOUR_W*k +: COLOUR_W];
    end
  end

  // Stage p0: owner's pixel and release conditions, combinational from inputs
  always_comb begin
    x_p0        = x_arr[owner];
    y_p0        = y_arr[owner];
    c_p0        = c_arr[owner];
    vld_p0      = (state == ARB_OWN) && vld_w[owner];
    last_p0     = vld_p0 && last_w[owner];
    drop_p0     = (state == ARB_OWN) && !req_w[owner];
    hold_exp_p0 = (state == ARB_OWN) && (hold_cnt == HOLD_LAST);
    rel_p0      = last_p0 || drop_p0;
    on_scr_p0   = on_screen(x_p0, y_p0);
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    ptr_nxt     = ptr;
    gnt_nxt     = oGnt;
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_nxt = ARB_OWN;
          owner_nxt = pick_idx;
          gnt_nxt   = pick_gnt;
          hold_nxt  = '0;
        end
      end
      ARB_OWN: begin
        hold_nxt = hold_cnt + HOLD_W'(1);
        if (rel_p0 || hold_exp_p0) begin
          state_nxt   = ARB_IDLE;
          owner_nxt   = '0;
          ptr_nxt     = owner;
          gnt_nxt     = '0;
          hold_nxt    = '0;
          timeout_nxt = !rel_p0;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      ptr      <= OWNER_W'(N_CLIENTS - 1);
      oGnt     <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      oGnt     <= gnt_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Stage p1: registered pixel port; coordinates hold when no owner pixel arrives
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      oX       <= '0;
      oY       <= '0;
      oColour  <= COLOUR_BLACK;
      oPlot    <= 1'b0;
      oClipped <= 1'b0;
      oTimeout <= 1'b0;
    end else begin
      oPlot    <= vld_p0 && on_scr_p0;
      oClipped <= vld_p0 && !on_scr_p0;
      oTimeout <= timeout_nxt;
      if (vld_p0) begin
        oX      <= x_p0;
        oY      <= y_p0;
        oColour <= c_p0;
      end
    end
  end

  assign oBusy  = (state == ARB_OWN);
  assign oOwner = owner;

endmodule
